allophone_sequencer: RTL and testbench
======================================

// Module: allophone_sequencer
// PURPOSE
//  Parametrised allophone sequencer between a host/board top level and SPEECH256_TOP.
//  Buffers allophone codes in a FIFO and derives the speech core clock enable from clk.
//  Runs the ldq/data_stb handshake autonomously, with one-shot or loop playback.
//  Reports a handshake timeout and FIFO overflow.
// PARAMETERS
//  DATA_W   6    allophone code width
//  DEPTH    16   FIFO entries; power of two, >=2
//  DIV      20   clk cycles per ce pulse; >=2
//  TIMEOUT  255  max ce pulses to wait for each ldq edge before error
// PORTS
//  clk        in   1            single clock; every flop is on its rising edge
//  rst        in   1            synchronous, active-high reset
//  wr_data    in   DATA_W       allophone code to enqueue
//  wr_stb     in   1            enqueue wr_data this cycle
//  flush      in   1            clear FIFO, abort sequencing, clear errors
//  play_en    in   1            level; allows new allophones to be issued
//  loop_mode  in   1            0: pop after issue; 1: retain entries, replay circularly
//  ldq        in   1            speech core ready-for-load, from SPEECH256_TOP
//  ce         out  1            one-clk pulse every DIV clk cycles; speech core enable
//  spk_data   out  DATA_W       allophone code to core (data_in)
//  spk_stb    out  1            load strobe to core (data_stb)
//  busy       out  1            FSM not in S_IDLE
//  empty      out  1            FIFO holds 0 entries
//  full       out  1            FIFO holds DEPTH entries
//  level      out  $clog2(DEPTH)+1  FIFO occupancy
//  ovf        out  1            sticky: write dropped because FIFO was full
//  tmo        out  1            sticky: ldq handshake timeout
// BEHAVIOUR
//  Reset: all outputs 0 except empty=1; FIFO pointers, divider and FSM cleared.
//  Divider: cnt runs 0..DIV-1; ce=1 in the cycle cnt==DIV-1. First ce occurs DIV cycles after rst release.
//  FIFO: wr_ptr, rd_ptr, play_ptr, level count.
//   - A write while full is dropped and sets ovf.
//   - A write and a pop in the same cycle while full is accepted.
//   - flush beats wr_stb in the same cycle.
//  FSM states: S_IDLE, S_ISSUE, S_WAITLO, S_WAITHI.
//   S_IDLE  : ->S_ISSUE when play_en && !empty && ldq.
//             Latch the code into spk_data: FIFO[rd_ptr] if loop_mode=0, else FIFO[play_ptr].
//   S_ISSUE : spk_stb=1; stay through the next ce pulse inclusive, so the core sees exactly one strobed ce.
//             Then loop_mode=0: pop (rd_ptr++, level--). loop_mode=1: play_ptr++.
//             play_ptr wraps to rd_ptr when it reaches wr_ptr.
//             Then ->S_WAITLO.
//   S_WAITLO: wait for ldq==0 (core accepted) -> S_WAITHI.
//   S_WAITHI: wait for ldq==1 -> S_IDLE.
//  Timeout: S_WAITLO/S_WAITHI count ce pulses. At TIMEOUT, set tmo and return to S_IDLE.
//   The entry counts as consumed.
//  spk_data holds its last value outside S_ISSUE. spk_stb is 1 only in S_ISSUE.
//  loop_mode is sampled only on the S_IDLE->S_ISSUE transition.
//   Switching 1->0 resumes popping from rd_ptr; play_ptr is reloaded from rd_ptr on every 0->1 sample.
//  play_en=0 takes effect at the next S_IDLE; the allophone in flight completes.
//  flush in any state: next cycle FSM=S_IDLE, spk_stb=0, level=0, empty=1, ovf=tmo=0.
//   The divider keeps running.
//  rst mid-operation: identical to the reset values above, divider included.
// TESTING
//  1 DIV=4: release rst -> ce high on cycles 4, 8, 12; ce never high two cycles in a row.
//  2 loop_mode=0, write 0x05, 0x2A, 0x11, ldq model low 3 ce after strobe then high after 10 ce
//    -> spk_data sequence 05, 2A, 11; one spk_stb window each, each spanning one ce;
//    empty=1 and busy=0 at end.
//  3 DEPTH=4: write 5 codes, play_en=0 -> full=1, level=4, ovf=1, 5th code never issued.
//    Then flush -> level=0, ovf=0.
//  4 loop_mode=1 with 0x01, 0x02 stored -> issues 01, 02, 01, 02, 01; level stays 2.
//  5 TIMEOUT=8, ldq held 1 after strobe -> tmo=1 after 8 ce; next entry issued when ldq remains 1.
//  6 flush asserted in S_ISSUE -> spk_stb=0 next cycle, busy=0, no further strobes.

Source files
------------

// File: rtl/allophone_sequencer_if.sv
// rtl/allophone_sequencer_if.sv - speech core link: enable, load strobe, code and ready-for-load
interface allophone_sequencer_if #(
  parameter int DATA_W = 6
);
  logic              ce;
  logic              spk_stb;
  logic [DATA_W-1:0] spk_data;
  logic              ldq;

  modport master (input ldq, output ce, output spk_stb, output spk_data);
  modport slave  (output ldq, input ce, input spk_stb, input spk_data);
endinterface

// File: rtl/allophone_sequencer.sv
// rtl/allophone_sequencer.sv - allophone FIFO, ce divider and ldq/data_stb handshake FSM
// One-shot or circular playback, with sticky overflow and handshake-timeout flags.
module allophone_sequencer #(
  parameter int DATA_W  = 6,
  parameter int DEPTH   = 16,
  parameter int DIV     = 20,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     wr_stb_i,
  input  logic                     flush_i,
  input  logic                     play_en_i,
  input  logic                     loop_mode_i,
  allophone_sequencer_if.master    spk_if,
  output logic                     busy_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     ovf_o,
  output logic                     tmo_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(DIV);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_WAITLO = 2'd2;
  localparam logic [1:0] S_WAITHI = 2'd3;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, play_ptr_q, play_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] spk_data_q, spk_data_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              loop_q, loop_d, ovf_q, ovf_d, tmo_q, tmo_d;
  logic              ce, full, empty, pop, adv, wr_acc;

  always_comb begin
    ce         = (cnt_q == CNT_MAX);
    cnt_d      = ce ? '0 : cnt_q + CW'(1);
    full       = (level_q == LW'(DEPTH));
    empty      = (level_q == '0);
    state_d    = state_q;
    spk_data_d = spk_data_q;
    loop_d     = loop_q;
    tcnt_d     = tcnt_q;
    play_ptr_d = play_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    ovf_d      = ovf_q;
    tmo_d      = tmo_q;
    pop        = 1'b0;
    adv        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (play_en_i && !empty && spk_if.ldq) begin
          state_d = S_ISSUE;
          loop_d  = loop_mode_i;
          if (loop_mode_i && loop_q) begin
            spk_data_d = mem_q[play_ptr_q];
          end else begin
            spk_data_d = mem_q[rd_ptr_q];
            play_ptr_d = rd_ptr_q;
          end
        end
      end
      S_ISSUE: begin
        // Leave on the ce we strobed so the core sees exactly one load.
        if (ce) begin
          state_d = S_WAITLO;
          tcnt_d  = '0;
          adv     = loop_q;
          pop     = !loop_q;
        end
      end
      default: begin
        if (spk_if.ldq == (state_q == S_WAITHI)) begin
          state_d = (state_q == S_WAITHI) ? S_IDLE : S_WAITHI;
          tcnt_d  = '0;
        end else if (ce) begin
          if (tcnt_q == TMO_MAX) begin
            tmo_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
    endcase

    if (adv) begin
      play_ptr_d = (play_ptr_q + AW'(1) == wr_ptr_q) ? rd_ptr_q : play_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    // A pop frees the slot in the same cycle, so a write while full is taken then.
    wr_acc = wr_stb_i && (!full || pop) && !flush_i;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (wr_stb_i && !wr_acc && !flush_i) begin
      ovf_d = 1'b1;
    end
    level_d = level_q + LW'(wr_acc) - LW'(pop);

    if (flush_i) begin
      state_d    = S_IDLE;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      play_ptr_d = '0;
      level_d    = '0;
      loop_d     = 1'b0;
      tcnt_d     = '0;
      ovf_d      = 1'b0;
      tmo_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      play_ptr_q <= '0;
      level_q    <= '0;
      state_q    <= S_IDLE;
      spk_data_q <= '0;
      loop_q     <= 1'b0;
      tcnt_q     <= '0;
      ovf_q      <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      play_ptr_q <= play_ptr_d;
      level_q    <= level_d;
      state_q    <= state_d;
      spk_data_q <= spk_data_d;
      loop_q     <= loop_d;
      tcnt_q     <= tcnt_d;
      ovf_q      <= ovf_d;
      tmo_q      <= tmo_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign spk_if.ce       = ce;
  assign spk_if.spk_stb  = (state_q == S_ISSUE);
  assign spk_if.spk_data = spk_data_q;
  assign busy_o          = (state_q != S_IDLE);
  assign empty_o         = empty;
  assign full_o          = full;
  assign level_o         = level_q;
  assign ovf_o           = ovf_q;
  assign tmo_o           = tmo_q;
endmodule

// File: tb/tb_allophone_sequencer.sv
// tb/tb_allophone_sequencer.sv - scoreboard bench with a behavioural speech core driving ldq
module tb_allophone_sequencer;
  localparam int DATA_W  = 6;
  localparam int DEPTH   = 4;
  localparam int DIV     = 4;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] wr_data;
  logic              wr_stb, flush, play_en, loop_mode;
  logic              busy, empty, full, ovf, tmo;
  logic [2:0]        level;

  allophone_sequencer_if #(.DATA_W(DATA_W)) spk_if ();

  allophone_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DIV(DIV), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .wr_data_i(wr_data), .wr_stb_i(wr_stb), .flush_i(flush),
    .play_en_i(play_en), .loop_mode_i(loop_mode), .spk_if(spk_if),
    .busy_o(busy), .empty_o(empty), .full_o(full), .level_o(level), .ovf_o(ovf), .tmo_o(tmo)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  logic [DATA_W-1:0] exp_q[$];
  int stb_count = 0;
  int ce_in_win = 0;
  bit stb_prev = 1'b0;
  bit abort_win = 1'b0;
  bit hold_ldq = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Monitor: pops the scoreboard on each strobe window and counts strobed ce pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (spk_if.spk_stb && !stb_prev) begin
        stb_count++;
        ce_in_win = 0;
        check("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("spk_data", spk_if.spk_data, exp_q.pop_front());
      end
      if (spk_if.spk_stb && spk_if.ce) ce_in_win++;
      if (!spk_if.spk_stb && stb_prev) begin
        if (abort_win) abort_win = 1'b0;
        else check("stb_ce_count", ce_in_win, 1);
      end
      stb_prev = spk_if.spk_stb;
    end
  end

  // Speech core model: ldq low 3 ce after the strobed ce, high again at the 10th.
  initial begin
    int cst, ccnt;
    cst = 0;
    ccnt = 0;
    spk_if.ldq = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        spk_if.ldq = 1'b1;
        cst = 0;
      end else if (cst == 0) begin
        if (spk_if.spk_stb && spk_if.ce && !hold_ldq) begin
          cst = 1;
          ccnt = 0;
        end
      end else if (spk_if.ce) begin
        ccnt++;
        if (ccnt == 3) spk_if.ldq = 1'b0;
        if (ccnt == 10) begin
          spk_if.ldq = 1'b1;
          cst = 0;
        end
      end
    end
  end

  task automatic write_code(input logic [DATA_W-1:0] c, input bit expect_issue);
    wr_data = c;
    wr_stb = 1'b1;
    if (expect_issue) exp_q.push_back(c);
    @(negedge clk);
    wr_stb = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_idle(input int max, input bit need_empty, input string tag);
    int i;
    for (i = 0; i < max; i++) begin
      @(negedge clk);
      #1;
      if (!busy && (empty || !need_empty)) break;
    end
    check(tag, i < max, 1);
  endtask

  task automatic wait_stb(input int target, input string tag);
    int i;
    for (i = 0; i < 2000; i++) begin
      @(negedge clk);
      #1;
      if (stb_count >= target) break;
    end
    check(tag, i < 2000, 1);
  endtask

  initial begin
    int base, nce, i;
    logic [DATA_W-1:0] codes [3];
    rst = 1'b1; wr_stb = 1'b0; wr_data = '0; flush = 1'b0; play_en = 1'b0; loop_mode = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ce", spk_if.ce, 0);
    check("rst_stb", spk_if.spk_stb, 0);
    check("rst_data", spk_if.spk_data, 0);
    check("rst_busy", busy, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_level", level, 0);
    check("rst_ovf", ovf, 0);
    check("rst_tmo", tmo, 0);

    rst = 1'b0;
    for (int k = 0; k < 13; k++) begin
      check("ce_cycle", spk_if.ce, ((k + 1) % DIV) == 0);
      @(negedge clk);
    end

    codes[0] = 6'h05; codes[1] = 6'h2A; codes[2] = 6'h11;
    base = stb_count;
    for (int k = 0; k < 3; k++) write_code(codes[k], 1'b1);
    play_en = 1'b1;
    wait_idle(1500, 1'b1, "t2_done");
    check("t2_count", stb_count - base, 3);
    check("t2_empty", empty, 1);
    check("t2_busy", busy, 0);

    play_en = 1'b0;
    for (int k = 0; k < 5; k++) write_code(DATA_W'(6'h21 + k), k < 4);
    check("t3_full", full, 1);
    check("t3_level", level, 4);
    check("t3_ovf", ovf, 1);
    base = stb_count;
    play_en = 1'b1;
    wait_idle(2000, 1'b1, "t3_done");
    repeat (20) @(negedge clk);
    check("t3_count", stb_count - base, 4);
    check("t3_ovf_sticky", ovf, 1);
    do_flush();
    check("t3_flush_level", level, 0);
    check("t3_flush_ovf", ovf, 0);
    check("t3_flush_empty", empty, 1);

    play_en = 1'b0;
    loop_mode = 1'b1;
    write_code(6'h01, 1'b0);
    write_code(6'h02, 1'b0);
    for (int k = 0; k < 5; k++) exp_q.push_back(DATA_W'((k % 2) + 1));
    base = stb_count;
    play_en = 1'b1;
    wait_stb(base + 5, "t4_reach5");
    play_en = 1'b0;
    wait_idle(500, 1'b0, "t4_done");
    repeat (20) @(negedge clk);
    check("t4_count", stb_count - base, 5);
    check("t4_level", level, 2);
    loop_mode = 1'b0;
    do_flush();
    check("t4_flush_empty", empty, 1);

    hold_ldq = 1'b1;
    play_en = 1'b0;
    write_code(6'h33, 1'b1);
    write_code(6'h0C, 1'b1);
    base = stb_count;
    play_en = 1'b1;
    wait_stb(base + 1, "t5_first");
    for (i = 0; i < 20 && spk_if.spk_stb; i++) begin
      @(negedge clk);
      #1;
    end
    nce = 0;
    for (i = 0; i < 200; i++) begin
      if (tmo) break;
      if (spk_if.ce) nce++;
      @(negedge clk);
      #1;
    end
    check("t5_tmo_ce", nce, TIMEOUT);
    wait_idle(500, 1'b1, "t5_done");
    check("t5_count", stb_count - base, 2);
    check("t5_tmo", tmo, 1);
    hold_ldq = 1'b0;
    do_flush();
    check("t5_flush_tmo", tmo, 0);

    play_en = 1'b0;
    for (int k = 0; k < 3; k++) write_code(DATA_W'(6'h15 + k), 1'b1);
    play_en = 1'b1;
    for (i = 0; i < 600; i++) begin
      @(negedge clk);
      #1;
      if (spk_if.spk_stb && !spk_if.ce) break;
    end
    check("t6_found_issue", i < 600, 1);
    abort_win = 1'b1;
    do_flush();
    check("t6_stb", spk_if.spk_stb, 0);
    check("t6_busy", busy, 0);
    check("t6_level", level, 0);
    exp_q.delete();
    base = stb_count;
    repeat (60) @(negedge clk);
    check("t6_no_stb", stb_count, base);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
